// File: rtl/modbus_crc_checker.sv
// Modbus RTU 7-byte frame checker: bit-serial CRC-16/MODBUS over bytes 0..4, compared with bytes 5..6.
// Optional ADDR_FILTER_EN: drop frames not addressed to SLAVE_ADDR or broadcast.
module modbus_crc_checker #(
   parameter logic [15:0] CRC_INIT   = 16'hFFFF,
   parameter logic [15:0] CRC_POLY   = 16'hA001,
   parameter logic [7:0]  SLAVE_ADDR = 8'h01
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        Frame_Done_Sig,
   input  logic [55:0] Frame_Data,
   output logic        Frame_En_Sig,
   input  logic        Out_En_Sig,
   output logic        Check_Done_Sig,
   output logic [55:0] Check_Data,
   output logic        CRC_OK,
   output logic [15:0] Calc_CRC,
   output logic [7:0]  Err_Count
);

   typedef enum logic [1:0] {IDLE, CALC, CHECK, DONE} state_t;

   state_t      state, state_nxt;
   logic [55:0] frame;
   logic [15:0] crc, crc_nxt;
   logic [5:0]  bit_cnt;
   logic        addr_ok, crc_bad, err_evt;

`ifdef ADDR_FILTER_EN
   assign addr_ok = (frame[7:0] == SLAVE_ADDR) || (frame[7:0] == 8'h00);
`else
   // every address accepted; the compare only keeps the parameter referenced
   assign addr_ok = 1'b1 | (frame[7:0] == SLAVE_ADDR);
`endif

   assign Frame_En_Sig = (state == IDLE);
   assign crc_bad      = (crc != frame[55:40]);
   assign crc_nxt      = (crc >> 1) ^ ((crc[0] ^ frame[bit_cnt]) ? CRC_POLY : 16'h0000);
   // an overrun and a CRC failure in the same cycle count once
   assign err_evt      = (Frame_Done_Sig && state != IDLE) ||
                         (state == CHECK && addr_ok && crc_bad);

   always_ff @(posedge CLK) begin
      if (!RSTn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (Frame_Done_Sig) state_nxt = CALC;
         CALC:  if (bit_cnt == 6'd39) state_nxt = CHECK;
         CHECK: state_nxt = addr_ok ? DONE : IDLE;
         DONE:  if (Check_Done_Sig && Out_En_Sig) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         frame          <= '0;
         crc            <= '0;
         bit_cnt        <= '0;
         Check_Done_Sig <= 1'b0;
         Check_Data     <= '0;
         CRC_OK         <= 1'b0;
         Calc_CRC       <= '0;
         Err_Count      <= '0;
      end else begin
         case (state)
            IDLE: if (Frame_Done_Sig) begin
               frame   <= Frame_Data;
               crc     <= CRC_INIT;
               bit_cnt <= '0;
            end
            CALC: begin
               crc     <= crc_nxt;
               bit_cnt <= bit_cnt + 6'd1;
            end
            CHECK: if (addr_ok) begin
               Calc_CRC   <= crc;
               CRC_OK     <= !crc_bad;
               Check_Data <= frame;
            end
            DONE: begin
               // raised one cycle into DONE, dropped on the accepting edge
               if (!Check_Done_Sig)  Check_Done_Sig <= 1'b1;
               else if (Out_En_Sig)  Check_Done_Sig <= 1'b0;
            end
            default: ;
         endcase
         if (err_evt && Err_Count != 8'hFF) Err_Count <= Err_Count + 8'd1;
      end
   end

endmodule
